// File: rtl/seq_pkg.sv
// Shared types and helpers for the single-bit sequence link blocks.
// Holds the transmitter state encoding, the default idle level and pattern length clamping.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic IDLE_BIT_DEF = 1'b0;

   // A length of zero, or one longer than the pattern register, means "send the full register".
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
      return (len == 0 || len > pat_w) ? pat_w : len;
   endfunction

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-in serial-out shifter, MSB-first, with a programmable number of bits.
// The load value is left-aligned, and its MSB leaves on the load edge, so rem_o counts only the bits still queued behind it.
import seq_pkg::*;

module seq_piso_shift #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [PAT_W-1:0] pat_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             shift_i,
   output logic             head_o,
   output logic [LEN_W-1:0] rem_o
);

   logic [PAT_W-1:0] sr_q, sr_d;
   logic [LEN_W-1:0] rem_q, rem_d;

   always_comb begin
      sr_d  = sr_q;
      rem_d = rem_q;
      if (load_i) begin
         sr_d  = pat_i << 1;
         rem_d = len_i - LEN_W'(1);
      end else if (shift_i) begin
         sr_d  = sr_q << 1;
         rem_d = rem_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q  <= '0;
         rem_q <= '0;
      end else begin
         sr_q  <= sr_d;
         rem_q <= rem_d;
      end
   end

   assign head_o = sr_q[PAT_W-1];
   assign rem_o  = rem_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated with optional idle gaps.
// All outputs are registered; the first bit appears in the cycle after the load is accepted.
import seq_pkg::*;

module seq_pattern_tx #(
   parameter int   PAT_W    = 8,
   parameter int   LEN_W    = 4,
   parameter int   CNT_W    = 8,
   parameter int   GAP_W    = 4,
   parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [PAT_W-1:0] load_pattern,
   input  logic [LEN_W-1:0] load_len,
   input  logic [CNT_W-1:0] load_reps,
   input  logic [GAP_W-1:0] load_gap,
   input  logic             abort,
   output logic             out_bit,
   output logic             out_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   state_t           state_q;
   logic             out_bit_q, out_valid_q, frame_start_q, done_q;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic [CNT_W-1:0] rep_q;
   logic [GAP_W-1:0] gap_cfg_q, gap_cnt_q;

   logic [LEN_W-1:0] load_len_c;
   logic [PAT_W-1:0] load_aligned_c;
   logic             accept_c, restart_c, shift_c, rep_end_c;
   logic             piso_load, piso_head;
   logic [PAT_W-1:0] piso_pat;
   logic [LEN_W-1:0] piso_len, piso_rem;
   logic             first_bit_c;

   assign load_len_c     = LEN_W'(clamp_len(32'(load_len), PAT_W));
   assign load_aligned_c = load_pattern << (PAT_W - int'(load_len_c));

   assign accept_c  = (state_q == IDLE) && load_valid;
   assign rep_end_c = (state_q == SEND) && (piso_rem == '0);
   assign shift_c   = (state_q == SEND) && !abort && (piso_rem != '0);
   // A new repetition starts either straight after the last bit (no gap) or on the final gap cycle.
   assign restart_c = !abort &&
                      ((rep_end_c && (rep_q != '0) && (gap_cfg_q == '0)) ||
                       ((state_q == GAP) && (gap_cnt_q == GAP_W'(1))));

   assign piso_load   = accept_c || restart_c;
   assign piso_pat    = accept_c ? load_aligned_c : pat_q;
   assign piso_len    = accept_c ? load_len_c : len_q;
   assign first_bit_c = piso_pat[PAT_W-1];

   seq_piso_shift #(
      .PAT_W(PAT_W),
      .LEN_W(LEN_W)
   ) u_shift (
      .clk    (clk),
      .reset  (reset),
      .load_i (piso_load),
      .pat_i  (piso_pat),
      .len_i  (piso_len),
      .shift_i(shift_c),
      .head_o (piso_head),
      .rem_o  (piso_rem)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         out_bit_q     <= IDLE_BIT;
         out_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         done_q        <= 1'b0;
         pat_q         <= '0;
         len_q         <= '0;
         rep_q         <= '0;
         gap_cfg_q     <= '0;
         gap_cnt_q     <= '0;
      end else begin
         frame_start_q <= 1'b0;
         done_q        <= 1'b0;
         case (state_q)
            IDLE: begin
               out_bit_q   <= IDLE_BIT;
               out_valid_q <= 1'b0;
               if (accept_c) begin
                  pat_q         <= load_aligned_c;
                  len_q         <= load_len_c;
                  rep_q         <= load_reps;
                  gap_cfg_q     <= load_gap;
                  state_q       <= SEND;
                  out_bit_q     <= first_bit_c;
                  out_valid_q   <= 1'b1;
                  frame_start_q <= 1'b1;
               end
            end
            SEND: begin
               if (abort) begin
                  state_q     <= IDLE;
                  out_bit_q   <= IDLE_BIT;
                  out_valid_q <= 1'b0;
               end else if (shift_c) begin
                  out_bit_q <= piso_head;
               end else if (rep_q != '0) begin
                  rep_q <= rep_q - CNT_W'(1);
                  if (restart_c) begin
                     out_bit_q     <= first_bit_c;
                     frame_start_q <= 1'b1;
                  end else begin
                     state_q     <= GAP;
                     gap_cnt_q   <= gap_cfg_q;
                     out_bit_q   <= IDLE_BIT;
                     out_valid_q <= 1'b0;
                  end
               end else begin
                  state_q     <= IDLE;
                  done_q      <= 1'b1;
                  out_bit_q   <= IDLE_BIT;
                  out_valid_q <= 1'b0;
               end
            end
            GAP: begin
               if (abort) begin
                  state_q     <= IDLE;
                  out_bit_q   <= IDLE_BIT;
                  out_valid_q <= 1'b0;
               end else if (restart_c) begin
                  state_q       <= SEND;
                  out_bit_q     <= first_bit_c;
                  out_valid_q   <= 1'b1;
                  frame_start_q <= 1'b1;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GAP_W'(1);
               end
            end
            default: begin
               state_q     <= IDLE;
               out_bit_q   <= IDLE_BIT;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_bit     = out_bit_q;
   assign out_valid   = out_valid_q;
   assign frame_start = frame_start_q;
   assign done        = done_q;
   assign busy        = (state_q != IDLE);
   assign load_ready  = (state_q == IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: queue-based per-cycle output model plus directed literal checks.
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load_valid = 1'b0;
   logic       load_ready;
   logic [7:0] load_pattern = '0;
   logic [3:0] load_len = '0;
   logic [7:0] load_reps = '0;
   logic [3:0] load_gap = '0;
   logic       abort = 1'b0;
   logic       out_bit, out_valid, frame_start, busy, done;

   int n_chk = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   seq_pattern_tx dut (
      .clk         (clk),
      .reset       (reset),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_pattern(load_pattern),
      .load_len    (load_len),
      .load_reps   (load_reps),
      .load_gap    (load_gap),
      .abort       (abort),
      .out_bit     (out_bit),
      .out_valid   (out_valid),
      .frame_start (frame_start),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected output of every future cycle: {bit, valid, frame_start, done}.
   typedef struct packed {
      logic b;
      logic v;
      logic f;
      logic d;
   } ent_t;

   ent_t q[$];
   ent_t exp_e = '0;
   logic exp_ready = 1'b1;

   task automatic push_run(input logic [7:0] p, input logic [3:0] l_in, input logic [7:0] r,
                           input logic [3:0] g);
      int l;
      l = (l_in == 0 || l_in > 8) ? 8 : int'(l_in);
      for (int rep = 0; rep <= int'(r); rep++) begin
         for (int i = 0; i < l; i++) q.push_back(ent_t'({p[l-1-i], 1'b1, (i == 0), 1'b0}));
         if (rep < int'(r))
            for (int k = 0; k < int'(g); k++) q.push_back(ent_t'(4'b0000));
      end
      q.push_back(ent_t'(4'b0001));
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (reset) q.delete();
         else if (q.size() == 0) begin
            if (load_valid) push_run(load_pattern, load_len, load_reps, load_gap);
         end else if (abort) q.delete();
         if (q.size() != 0) exp_e = q.pop_front();
         else exp_e = ent_t'(4'b0000);
         exp_ready = (q.size() == 0);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("m_out_bit", 64'(out_bit), 64'(exp_e.b));
            chk("m_out_valid", 64'(out_valid), 64'(exp_e.v));
            chk("m_frame_start", 64'(frame_start), 64'(exp_e.f));
            chk("m_done", 64'(done), 64'(exp_e.d));
            chk("m_load_ready", 64'(load_ready), 64'(exp_ready));
            chk("m_busy", 64'(busy), 64'(!exp_ready));
         end
      end
   end

   // Accepts a load at the next edge and records n cycles of outputs, bit k-1 = cycle T+k.
   task automatic run_cap(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r,
                          input logic [3:0] g, input int n, input int ab_k, input int rs_k,
                          input int hold_k, output logic [63:0] vb, output logic [63:0] vv,
                          output logic [63:0] vf, output logic [63:0] vd, output logic [63:0] vr);
      vb = '0; vv = '0; vf = '0; vd = '0; vr = '0;
      load_pattern = p; load_len = l; load_reps = r; load_gap = g;
      load_valid = 1'b1;
      @(posedge clk); #1;
      if (hold_k == 0) begin
         load_valid = 1'b0;
         load_pattern = ~p; load_len = l + 4'd3; load_reps = r + 8'd5; load_gap = g + 4'd2;
      end
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         vb[k-1] = out_bit; vv[k-1] = out_valid; vf[k-1] = frame_start;
         vd[k-1] = done; vr[k-1] = load_ready;
         if (k == ab_k) abort = 1'b1;
         if (k == rs_k) reset = 1'b1;
         if (k == hold_k) load_valid = 1'b0;
         @(posedge clk); #1;
         abort = 1'b0;
         reset = 1'b0;
      end
   endtask

   logic [63:0] vb, vv, vf, vd, vr;
   int vcnt, dcnt;

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_bit", 64'(out_bit), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_frame_start", 64'(frame_start), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_load_ready", 64'(load_ready), 64'd1);
      cmp_en = 1'b1;
      @(posedge clk); #1;

      run_cap(8'b0000_1011, 4'd4, 8'd0, 4'd0, 6, 0, 0, 0, vb, vv, vf, vd, vr);
      chk("t1_bits", vb, 64'h0D); chk("t1_valid", vv, 64'h0F);
      chk("t1_frame", vf, 64'h01); chk("t1_done", vd, 64'h10); chk("t1_ready", vr, 64'h30);

      run_cap(8'b0000_1011, 4'd4, 8'd2, 4'd0, 14, 0, 0, 0, vb, vv, vf, vd, vr);
      chk("t2_bits", vb, 64'h0DDD); chk("t2_valid", vv, 64'h0FFF);
      chk("t2_frame", vf, 64'h0111); chk("t2_done", vd, 64'h1000);

      run_cap(8'b0000_1011, 4'd4, 8'd1, 4'd3, 13, 0, 0, 0, vb, vv, vf, vd, vr);
      chk("t3_bits", vb, 64'h068D); chk("t3_valid", vv, 64'h078F);
      chk("t3_frame", vf, 64'h0081); chk("t3_done", vd, 64'h0800);

      run_cap(8'hA5, 4'd0, 8'd0, 4'd0, 10, 0, 0, 0, vb, vv, vf, vd, vr);
      chk("t4_bits", vb, 64'h0A5); chk("t4_valid", vv, 64'h0FF);
      chk("t4_done", vd, 64'h100);

      run_cap(8'b0000_1011, 4'd4, 8'd0, 4'd0, 5, 2, 0, 0, vb, vv, vf, vd, vr);
      chk("t5_abort_valid", vv, 64'h03); chk("t5_abort_ready", vr, 64'h1C);
      chk("t5_abort_done", vd, 64'h00); chk("t5_abort_bits", vb, 64'h01);

      run_cap(8'b0000_1011, 4'd4, 8'd0, 4'd0, 5, 0, 2, 0, vb, vv, vf, vd, vr);
      chk("t6_reset_valid", vv, 64'h03); chk("t6_reset_ready", vr, 64'h1C);
      chk("t6_reset_done", vd, 64'h00); chk("t6_reset_bits", vb, 64'h01);

      run_cap(8'b0000_1011, 4'd4, 8'd0, 4'd0, 10, 0, 0, 9, vb, vv, vf, vd, vr);
      chk("t7_b2b_valid", vv, 64'h1EF); chk("t7_b2b_ready", vr, 64'h210);
      chk("t7_b2b_done", vd, 64'h210); chk("t7_b2b_frame", vf, 64'h021);
      chk("t7_b2b_bits", vb, 64'h1AD);

      load_pattern = 8'h01; load_len = 4'd1; load_reps = 8'hFF; load_gap = 4'd0;
      load_valid = 1'b1;
      @(posedge clk); #1 load_valid = 1'b0;
      vcnt = 0; dcnt = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (out_valid) vcnt++;
         if (done) dcnt++;
      end
      @(posedge clk); #1;
      chk("t8_max_reps_bits", 64'(vcnt), 64'd256);
      chk("t8_max_reps_done", 64'(dcnt), 64'd1);

      for (int c = 0; c < 4000; c++) begin
         load_valid   = ($urandom_range(0, 2) == 0);
         load_pattern = 8'($urandom);
         load_len     = 4'($urandom_range(0, 15));
         load_reps    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20))
                                                    : 8'($urandom_range(0, 3));
         load_gap     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 3));
         abort        = ($urandom_range(0, 39) == 0);
         reset        = ($urandom_range(0, 599) == 0);
         @(posedge clk); #1;
      end
      load_valid = 1'b0; abort = 1'b0; reset = 1'b0;
      repeat (400) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
